fusion_ptch_integrator: RTL and testbench

Parametrised pitch-fusion integrator that sits between the inertial sensor interface and the balance controller. It integrates offset-compensated pitch rate and pulls the result toward an accelerometer-derived pitch (complementary fusion). It also runs a self-calibration phase that measures the gyro offset rather than using a fixed constant. It adds seeding from the accelerometer, saturating integration, and a registered valid/ready handshake.

---
 rtl/fusion_ptch_integrator.sv | 95 +++++++++
 tb/tb_fusion_ptch_integrator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fusion_ptch_integrator.sv
// fusion_ptch_integrator: gyro-offset self-calibration plus complementary pitch fusion with a saturating integrator.
module fusion_ptch_integrator #(
  parameter int DW = 16,
  parameter int FRAC = 11,
  parameter int FUSION_STEP = 1024,
  parameter int CAL_LOG2 = 4,
  parameter int ACC_GAIN = 327,
  parameter logic [DW-1:0] AZ_OFFSET = 16'h00A0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld,
  input  logic [DW-1:0] ptch_rt,
  input  logic [DW-1:0] AZ,
  input  logic          cal_req,
  output logic [DW-1:0] ptch,
  output logic          ptch_vld,
  output logic          rdy,
  output logic          sat
);
  localparam int IW = DW + FRAC;
  localparam int SW = DW + CAL_LOG2;
  localparam int PW = DW + 33;
  localparam logic signed [PW-1:0] DMAX = PW'((64'sd1 <<< (DW - 1)) - 1);
  localparam logic signed [PW-1:0] DMIN = -DMAX - 1;
  localparam logic signed [IW+1:0] IMAX = (IW + 2)'((64'sd1 <<< (IW - 1)) - 1);
  localparam logic signed [IW+1:0] IMIN = -IMAX - 1;
  localparam logic signed [IW+1:0] STEP = (IW + 2)'(FUSION_STEP);
  typedef enum logic {CAL, RUN} state_t;
  state_t                 state_q;
  logic signed [IW-1:0]   int_q, int_d;
  logic signed [SW-1:0]   sum_q, sum_d, off_w;
  logic [CAL_LOG2-1:0]    cnt_q;
  logic [DW-1:0]          off_q;
  logic                   pv_q, sat_q;
  logic signed [DW:0]     az_c, rate;
  logic signed [PW-1:0]   prod, shf;
  logic signed [DW-1:0]   ptch_acc;
  logic signed [IW+1:0]   corr, acc_sum;
  logic                   over, under;
  assign az_c     = $signed({AZ[DW-1], AZ}) - $signed({AZ_OFFSET[DW-1], AZ_OFFSET});
  assign prod     = PW'(az_c) * PW'(ACC_GAIN);
  assign shf      = prod >>> 13;
  assign ptch_acc = (shf > DMAX) ? DMAX[DW-1:0] : (shf < DMIN) ? DMIN[DW-1:0] : shf[DW-1:0];
  assign rate     = $signed({ptch_rt[DW-1], ptch_rt}) - $signed({off_q[DW-1], off_q});
  // Fusion direction compares against the pitch already registered, not the one being written.
  assign corr     = (ptch_acc > $signed(ptch)) ? STEP : -STEP;
  assign acc_sum  = (IW + 2)'(int_q) - (IW + 2)'(rate) + corr;
  assign over     = acc_sum > IMAX;
  assign under    = acc_sum < IMIN;
  assign int_d    = over ? IMAX[IW-1:0] : under ? IMIN[IW-1:0] : acc_sum[IW-1:0];
  assign sum_d    = sum_q + SW'($signed(ptch_rt));
  assign off_w    = sum_d >>> CAL_LOG2;
  assign ptch     = int_q[IW-1:FRAC];
  assign ptch_vld = pv_q;
  assign rdy      = (state_q == RUN);
  assign sat      = sat_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CAL;
      int_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      pv_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      if (cal_req) begin
        state_q <= CAL;
        sum_q   <= '0;
        cnt_q   <= '0;
      end else if (vld) begin
        if (state_q == CAL) begin
          if (cnt_q == '1) begin
            off_q   <= off_w[DW-1:0];
            int_q   <= {ptch_acc, {FRAC{1'b0}}};
            sum_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            state_q <= RUN;
            pv_q    <= 1'b1;
          end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          int_q <= int_d;
          sat_q <= sat_q | over | under;
          pv_q  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fusion_ptch_integrator.sv
// tb_fusion_ptch_integrator: directed and randomized checks against a plain-arithmetic pitch-fusion model.
module tb_fusion_ptch_integrator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [15:0] ptch_rt = '0;
  logic [15:0] AZ = '0;
  logic        cal_req = 1'b0;
  logic [15:0] ptch;
  logic        ptch_vld, rdy, sat;
  int n_chk = 0;
  int n_pass = 0;
  bit     m_run, m_sat, m_pv;
  longint m_sum, m_off, m_int;
  int     m_cnt;
  localparam longint IMAX = (64'sd1 <<< 26) - 1;
  localparam longint IMIN = -(64'sd1 <<< 26);

  fusion_ptch_integrator dut (
    .clk(clk), .rst(rst), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ), .cal_req(cal_req),
    .ptch(ptch), .ptch_vld(ptch_vld), .rdy(rdy), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic longint f_acc(input longint az);
    longint p;
    p = ((az - 160) * 327) >>> 13;
    return (p > 32767) ? 32767 : (p < -32768) ? -32768 : p;
  endfunction

  task automatic m_reset();
    m_run = 0; m_sat = 0; m_pv = 0; m_sum = 0; m_off = 0; m_int = 0; m_cnt = 0;
  endtask

  task automatic model(input bit v, input longint rt, input longint az, input bit cr);
    longint n, acc;
    m_pv = 0;
    acc = f_acc(az);
    if (cr) begin
      m_run = 0; m_sum = 0; m_cnt = 0;
    end else if (v && !m_run) begin
      if (m_cnt == 15) begin
        m_off = (m_sum + rt) >>> 4;
        m_int = acc * 2048;
        m_sum = 0; m_cnt = 0; m_sat = 0; m_run = 1; m_pv = 1;
      end else begin
        m_sum += rt; m_cnt++;
      end
    end else if (v) begin
      n = m_int - (rt - m_off) + ((acc > (m_int >>> 11)) ? 1024 : -1024);
      if (n > IMAX || n < IMIN) m_sat = 1;
      m_int = (n > IMAX) ? IMAX : (n < IMIN) ? IMIN : n;
      m_pv = 1;
    end
  endtask

  // One clock: drive, advance model, then compare every output after the edge.
  task automatic tick(input bit v, input logic [15:0] rt, input logic [15:0] az, input bit cr);
    vld = v; ptch_rt = rt; AZ = az; cal_req = cr;
    model(v, longint'($signed(rt)), longint'($signed(az)), cr);
    @(posedge clk);
    #1;
    chk("ptch", longint'($signed(ptch)), m_int >>> 11);
    chk("ptch_vld", ptch_vld, m_pv);
    chk("rdy", rdy, m_run);
    chk("sat", sat, m_sat);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic calibrate(input logic [15:0] rt);
    for (int i = 0; i < 16; i++) begin
      tick(1, rt, 16'h00A0, 0);
      if (i < 15) chk("cal_no_vld", ptch_vld, 0);
    end
    chk("cal_rdy", rdy, 1);
    chk("cal_vld", ptch_vld, 1);
    chk("cal_ptch", ptch, 16'h0000);
  endtask

  initial begin
    logic [15:0] prev;
    int hold;
    m_reset();
    #12 rst = 1'b0;
    // Calibration then steady-state alternation
    calibrate(16'h0050);
    chk("off_model", m_off, 80);
    tick(1, 16'h0050, 16'h00A0, 0);
    chk("steady0", ptch, 16'hFFFF);
    tick(1, 16'h0050, 16'h00A0, 0);
    chk("steady1", ptch, 16'h0000);
    tick(1, 16'h0050, 16'h00A0, 0);
    chk("steady2", ptch, 16'hFFFF);
    // Asynchronous reset mid-cycle from RUN
    #3 rst = 1'b1;
    #1;
    m_reset();
    chk("rst_ptch", ptch, 0);
    chk("rst_vld", ptch_vld, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_sat", sat, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick(1, 16'h0050, 16'h00A0, 0);
    chk("rst_stay_cal", rdy, 0);
    // Gyro step
    do_reset();
    calibrate(16'h0050);
    tick(1, 16'h0850, 16'h00A0, 0);
    chk("step1_int", m_int, -3072);
    chk("step1_ptch", ptch, 16'hFFFE);
    for (int i = 0; i < 7; i++) tick(1, 16'h0850, 16'h00A0, 0);
    chk("step8_int", m_int, -10240);
    chk("step8_ptch", ptch, 16'hFFFB);
    // Saturation: climb monotonically to the top and hold
    do_reset();
    calibrate(16'h0050);
    prev = ptch;
    hold = 0;
    for (int i = 0; i < 3000 && hold < 5; i++) begin
      tick(1, 16'h8000, 16'h00A0, 0);
      if ($signed(ptch) < $signed(prev)) chk("sat_mono", longint'($signed(ptch)), longint'($signed(prev)));
      prev = ptch;
      if (ptch == 16'h7FFF) hold++;
    end
    chk("sat_top", ptch, 16'h7FFF);
    chk("sat_flag", sat, 1);
    // Recalibration colliding with a sample
    tick(1, 16'h0050, 16'h00A0, 1);
    chk("col_vld", ptch_vld, 0);
    chk("col_rdy", rdy, 0);
    chk("col_hold", ptch, 16'h7FFF);
    for (int i = 0; i < 16; i++) begin
      tick(1, 16'h0060, 16'h00A0, 0);
      if (i < 15) chk("recal_hold", ptch, 16'h7FFF);
    end
    chk("recal_rdy", rdy, 1);
    chk("recal_sat", sat, 0);
    chk("recal_off", m_off, 96);
    tick(1, 16'h0060, 16'h00A0, 0);
    chk("recal_run", ptch, 16'hFFFF);
    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] rt, az;
      rt = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 400));
      az = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2000));
      tick($urandom_range(0, 9) < 7, rt, az, $urandom_range(0, 199) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
